// File: rtl/rat_maze_solver_param.sv
// Depth-first rat-in-maze solver over an N x N cell-wall memory, from (0,0) to (N-1,N-1).
// Keeps the solution path on a direction stack and can replay it on request.
module rat_maze_solver_param #(
   parameter int N     = 16,
   parameter int XW    = $clog2(N),
   parameter int DEPTH = N * N
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              run,
   output logic [2*XW-1:0]   mem_addr,
   output logic              mem_rd,
   input  logic              mem_dout,
   output logic              busy,
   output logic              done,
   output logic              fail,
   output logic [XW-1:0]     x_o,
   output logic [XW-1:0]     y_o,
   output logic [1:0]        move,
   output logic              move_valid,
   output logic              move_last,
   output logic [2*XW:0]     path_len
);
   localparam int SW    = 2 * XW + 1;
   localparam int CELLS = 1 << (2 * XW);
   localparam logic [XW-1:0] MAXC = XW'(N - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_INIT, S_CHECK, S_EVAL, S_ADVANCE, S_BACK, S_DONE, S_FAIL, S_REPLAY
   } state_t;

   typedef struct packed {
      logic          ok;
      logic [XW-1:0] x;
      logic [XW-1:0] y;
   } nb_t;

   function automatic nb_t neighbour(input logic [XW-1:0] x, input logic [XW-1:0] y,
                                     input logic [1:0] d);
      nb_t r;
      r.ok = 1'b1;
      r.x  = x;
      r.y  = y;
      case (d)
         2'b00:   if (y == '0)   r.ok = 1'b0; else r.y = y - XW'(1);
         2'b01:   if (x == MAXC) r.ok = 1'b0; else r.x = x + XW'(1);
         2'b10:   if (x == '0)   r.ok = 1'b0; else r.x = x - XW'(1);
         default: if (y == MAXC) r.ok = 1'b0; else r.y = y + XW'(1);
      endcase
      return r;
   endfunction

   state_t            state_q, state_d;
   logic [XW-1:0]     x_q, x_d, y_q, y_d;
   logic [2:0]        dir_q, dir_d;
   logic [SW-1:0]     sp_q, sp_d;
   logic [2*XW-1:0]   ridx_q, ridx_d;
   logic [1:0]        move_q, move_d;
   logic [CELLS-1:0]  visited_q, visited_d;
   logic [1:0]        stack_q [CELLS];

   logic              push_en;
   logic [SW-1:0]     sp_m1;
   logic [1:0]        top_dir;
   nb_t               cur_nb, scan_nb, cand_nb;
   logic              found;
   logic [1:0]        cand;

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      dir_d      = dir_q;
      sp_d       = sp_q;
      ridx_d     = ridx_q;
      move_d     = move_q;
      visited_d  = visited_q;
      push_en    = 1'b0;
      mem_rd     = 1'b0;
      mem_addr   = '0;
      move       = move_q;
      move_valid = 1'b0;
      move_last  = 1'b0;
      sp_m1      = sp_q - SW'(1);
      top_dir    = stack_q[sp_m1[2*XW-1:0]];
      cur_nb     = neighbour(x_q, y_q, dir_q[1:0]);

      // Skipped neighbours (out of range or visited) cost no cycles: pick the first live one.
      found   = 1'b0;
      cand    = '0;
      scan_nb = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         scan_nb = neighbour(x_q, y_q, 2'(i));
         if (!found && !dir_q[2] && (2'(i) >= dir_q[1:0]) && scan_nb.ok &&
             !visited_q[{scan_nb.y, scan_nb.x}]) begin
            found = 1'b1;
            cand  = 2'(i);
         end
      end
      cand_nb = neighbour(x_q, y_q, cand);

      case (state_q)
         S_IDLE, S_DONE, S_FAIL: begin
            if (start) begin
               state_d   = S_INIT;
               x_d       = '0;
               y_d       = '0;
               sp_d      = '0;
               dir_d     = '0;
               ridx_d    = '0;
               visited_d = '0;
               mem_rd    = 1'b1;
               mem_addr  = '0;
            end else if (state_q == S_DONE && run) begin
               state_d = S_REPLAY;
               ridx_d  = '0;
            end
         end
         S_INIT: begin
            if (mem_dout) begin
               state_d = S_FAIL;
            end else begin
               visited_d[0] = 1'b1;
               dir_d        = '0;
               state_d      = S_CHECK;
            end
         end
         S_CHECK: begin
            if (found) begin
               dir_d    = {1'b0, cand};
               mem_rd   = 1'b1;
               mem_addr = {cand_nb.y, cand_nb.x};
               state_d  = S_EVAL;
            end else begin
               state_d = S_BACK;
            end
         end
         S_EVAL: begin
            if (!mem_dout) begin
               state_d = S_ADVANCE;
            end else if (dir_q[1:0] == 2'b11) begin
               dir_d   = 3'b100;
               state_d = S_BACK;
            end else begin
               dir_d   = dir_q + 3'd1;
               state_d = S_CHECK;
            end
         end
         S_ADVANCE: begin
            push_en                          = 1'b1;
            sp_d                             = sp_q + SW'(1);
            x_d                              = cur_nb.x;
            y_d                              = cur_nb.y;
            visited_d[{cur_nb.y, cur_nb.x}]  = 1'b1;
            dir_d                            = '0;
            state_d = (cur_nb.x == MAXC && cur_nb.y == MAXC) ? S_DONE : S_CHECK;
         end
         S_BACK: begin
            if (sp_q == '0) begin
               x_d     = '0;
               y_d     = '0;
               state_d = S_FAIL;
            end else begin
               sp_d = sp_m1;
               case (top_dir)
                  2'b00:   y_d = y_q + XW'(1);
                  2'b01:   x_d = x_q - XW'(1);
                  2'b10:   x_d = x_q + XW'(1);
                  default: y_d = y_q - XW'(1);
               endcase
               // Resume after the popped direction; a popped 11 resumes exhausted.
               dir_d   = {1'b0, top_dir} + 3'd1;
               state_d = S_CHECK;
            end
         end
         S_REPLAY: begin
            move_valid = 1'b1;
            move       = stack_q[ridx_q];
            move_d     = stack_q[ridx_q];
            move_last  = ({1'b0, ridx_q} == sp_m1);
            if (move_last) begin
               ridx_d  = '0;
               state_d = S_DONE;
            end else begin
               ridx_d = ridx_q + (2*XW)'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         x_q       <= '0;
         y_q       <= '0;
         dir_q     <= '0;
         sp_q      <= '0;
         ridx_q    <= '0;
         move_q    <= '0;
         visited_q <= '0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         dir_q     <= dir_d;
         sp_q      <= sp_d;
         ridx_q    <= ridx_d;
         move_q    <= move_d;
         visited_q <= visited_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) begin
         assert (sp_q < SW'(DEPTH));
         stack_q[sp_q[2*XW-1:0]] <= dir_q[1:0];
      end
   end

   assign busy     = (state_q == S_INIT) || (state_q == S_CHECK) || (state_q == S_EVAL) ||
                     (state_q == S_ADVANCE) || (state_q == S_BACK) || (state_q == S_REPLAY);
   assign done     = (state_q == S_DONE) || (state_q == S_REPLAY);
   assign fail     = (state_q == S_FAIL);
   assign x_o      = x_q;
   assign y_o      = y_q;
   assign path_len = sp_q;

endmodule
